pong_game_sequencer: RTL and testbench

//  Game-flow controller for ShadyPong. Sits between the VGA frame timing and the ball/paddle datapath.

---
 rtl/pong_game_sequencer.sv | 143 ++++++++++++++
 tb/tb_pong_game_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_sequencer.sv
// Game-flow controller for ShadyPong: sequences attract/serve/play/point/game-over,
// gates per-frame ball/paddle steps, keeps scores and decides the winner.
module pong_game_sequencer #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int OVER_FRAMES  = 300,
  parameter int CNT_W        = 9
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [3:0] btns,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_step_en,
  output logic       paddle_step_en,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [2:0] phase,
  output logic       winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0]       WIN     = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_N = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] POINT_N = CNT_W'(POINT_FRAMES);
  localparam logic [CNT_W-1:0] OVER_N  = CNT_W'(OVER_FRAMES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       p1_d, p2_d;
  logic             dir_d, winner_d;
  logic             btns_any_q;
  logic             btn_press;
  logic             any_miss;

  assign btn_press = (|btns) & ~btns_any_q;
  assign any_miss  = miss_left | miss_right;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign phase     = state_q;

  // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p1_d     = score_p1;
    p2_d     = score_p2;
    dir_d    = serve_dir;
    winner_d = winner;
    case (state_q)
      IDLE: if (btn_press) begin
        state_d = SERVE;
        cnt_d   = '0;
        p1_d    = '0;
        p2_d    = '0;
      end
      SERVE: if (frame_tick) begin
        if (cnt_inc == SERVE_N) begin
          state_d = PLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PLAY: if (any_miss) begin
        // A double miss is a void rally: nobody scores, serve side stays.
        state_d = POINT;
        cnt_d   = '0;
        if (miss_right && !miss_left) begin
          if (score_p1 != WIN) p1_d = score_p1 + 4'd1;
          dir_d = 1'b1;
        end else if (miss_left && !miss_right) begin
          if (score_p2 != WIN) p2_d = score_p2 + 4'd1;
          dir_d = 1'b0;
        end
      end
      POINT: if (frame_tick) begin
        if (cnt_inc == POINT_N) begin
          cnt_d = '0;
          if (score_p1 == WIN || score_p2 == WIN) begin
            state_d  = OVER;
            winner_d = (score_p2 == WIN);
          end else begin
            state_d = SERVE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      OVER: begin
        if (btn_press && cnt_q == OVER_N) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (frame_tick && cnt_q != OVER_N) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      score_p1       <= '0;
      score_p2       <= '0;
      serve_dir      <= 1'b0;
      winner         <= 1'b0;
      ball_hold      <= 1'b1;
      ball_step_en   <= 1'b0;
      paddle_step_en <= 1'b0;
      // Preset high so buttons held through reset are not seen as a press.
      btns_any_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      score_p1       <= p1_d;
      score_p2       <= p2_d;
      serve_dir      <= dir_d;
      winner         <= winner_d;
      ball_hold      <= (state_d != PLAY);
      ball_step_en   <= frame_tick && (state_q == PLAY) && !any_miss;
      paddle_step_en <= frame_tick && (state_q == SERVE || state_q == PLAY);
      btns_any_q     <= |btns;
    end
  end

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Self-checking bench for pong_game_sequencer: directed vector table, hand-written
// corner sequences, then randomized stimulus against a behavioural game model.
module tb_pong_game_sequencer;

  localparam int WIN = 4, SRV = 3, PNT = 2, OVR = 4;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       frame_tick, miss_left, miss_right;
  logic [3:0] btns;
  logic       ball_step_en, paddle_step_en, ball_hold, serve_dir, winner;
  logic [3:0] score_p1, score_p2;
  logic [2:0] phase;

  pong_game_sequencer #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SRV), .POINT_FRAMES(PNT), .OVER_FRAMES(OVR), .CNT_W(4)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .frame_tick(frame_tick), .btns(btns),
    .miss_left(miss_left), .miss_right(miss_right),
    .ball_step_en(ball_step_en), .paddle_step_en(paddle_step_en), .ball_hold(ball_hold),
    .serve_dir(serve_dir), .score_p1(score_p1), .score_p2(score_p2),
    .phase(phase), .winner(winner)
  );

  always #5 CLK = ~CLK;

  int passed = 0, total = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: game rules in terms of frames elapsed in each phase.
  int  m_ph, m_frames, m_p1, m_p2, m_dir, m_win, m_ball, m_pad;
  bit  m_btn_was_down;

  task automatic model_reset();
    m_ph = S_IDLE; m_frames = 0; m_p1 = 0; m_p2 = 0; m_dir = 0; m_win = 0;
    m_ball = 0; m_pad = 0; m_btn_was_down = 1;
  endtask

  task automatic model_step(input bit t, input logic [3:0] b, input bit l, input bit r);
    bit pressed = (b != 0) && !m_btn_was_down;
    m_btn_was_down = (b != 0);
    m_ball = (t && m_ph == S_PLAY && !(l || r)) ? 1 : 0;
    m_pad  = (t && (m_ph == S_SERVE || m_ph == S_PLAY)) ? 1 : 0;
    if (m_ph == S_IDLE) begin
      if (pressed) begin m_ph = S_SERVE; m_frames = 0; m_p1 = 0; m_p2 = 0; end
    end else if (m_ph == S_SERVE) begin
      if (t) m_frames++;
      if (m_frames == SRV) begin m_ph = S_PLAY; m_frames = 0; end
    end else if (m_ph == S_PLAY) begin
      if (l || r) begin
        if (r && !l) begin m_p1 = (m_p1 < WIN) ? m_p1 + 1 : m_p1; m_dir = 1; end
        if (l && !r) begin m_p2 = (m_p2 < WIN) ? m_p2 + 1 : m_p2; m_dir = 0; end
        m_ph = S_POINT; m_frames = 0;
      end
    end else if (m_ph == S_POINT) begin
      if (t) m_frames++;
      if (m_frames == PNT) begin
        m_frames = 0;
        if (m_p1 == WIN || m_p2 == WIN) begin m_ph = S_OVER; m_win = (m_p2 == WIN); end
        else m_ph = S_SERVE;
      end
    end else begin
      if (pressed && m_frames == OVR) begin m_ph = S_IDLE; m_frames = 0; end
      else if (t && m_frames < OVR) m_frames++;
    end
  endtask

  task automatic cycle(input bit t, input logic [3:0] b, input bit l, input bit r);
    frame_tick = t; btns = b; miss_left = l; miss_right = r;
    @(posedge CLK);
    model_step(t, b, l, r);
    @(negedge CLK);
    frame_tick = 0; miss_left = 0; miss_right = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".phase"},  int'(phase),          m_ph);
    check({tag, ".p1"},     int'(score_p1),       m_p1);
    check({tag, ".p2"},     int'(score_p2),       m_p2);
    check({tag, ".dir"},    int'(serve_dir),      m_dir);
    check({tag, ".winner"}, int'(winner),         m_win);
    check({tag, ".hold"},   int'(ball_hold),      (m_ph != S_PLAY) ? 1 : 0);
    check({tag, ".ball"},   int'(ball_step_en),   m_ball);
    check({tag, ".pad"},    int'(paddle_step_en), m_pad);
  endtask

  // One full rally: serve countdown, a miss, then the point freeze.
  task automatic play_point(input bit l, input bit r);
    for (int i = 0; i < SRV; i++) begin cycle(1, 0, 0, 0); compare_model("rally"); end
    cycle(0, 0, l, r); compare_model("miss");
    for (int i = 0; i < PNT; i++) begin cycle(1, 0, 0, 0); compare_model("freeze"); end
  endtask

  typedef struct {
    bit t; logic [3:0] b; bit l; bit r;
    int ph; int p1; int p2; int dir; int hold; int ball; int pad;
  } vec_t;
  vec_t tbl[15];

  initial begin
    //          t  b  l  r   ph p1 p2 dir hold ball pad
    tbl[0]  = '{1, 0, 0, 0,  1, 0, 0, 0,  1,   0,   1};
    tbl[1]  = '{0, 0, 0, 0,  1, 0, 0, 0,  1,   0,   0};
    tbl[2]  = '{1, 0, 0, 0,  1, 0, 0, 0,  1,   0,   1};
    tbl[3]  = '{1, 0, 0, 0,  2, 0, 0, 0,  0,   0,   1};
    tbl[4]  = '{1, 0, 0, 0,  2, 0, 0, 0,  0,   1,   1};
    tbl[5]  = '{0, 0, 0, 0,  2, 0, 0, 0,  0,   0,   0};
    tbl[6]  = '{0, 0, 0, 1,  3, 1, 0, 1,  1,   0,   0};
    tbl[7]  = '{1, 0, 0, 0,  3, 1, 0, 1,  1,   0,   0};
    tbl[8]  = '{1, 0, 0, 0,  1, 1, 0, 1,  1,   0,   0};
    tbl[9]  = '{1, 0, 0, 0,  1, 1, 0, 1,  1,   0,   1};
    tbl[10] = '{1, 0, 0, 0,  1, 1, 0, 1,  1,   0,   1};
    tbl[11] = '{1, 0, 0, 0,  2, 1, 0, 1,  0,   0,   1};
    tbl[12] = '{1, 0, 1, 1,  3, 1, 0, 1,  1,   0,   1};
    tbl[13] = '{1, 0, 0, 0,  3, 1, 0, 1,  1,   0,   0};
    tbl[14] = '{1, 0, 0, 0,  1, 1, 0, 1,  1,   0,   0};

    // Reset with all buttons held; the held level must not start a game.
    rst_n = 0; frame_tick = 0; miss_left = 0; miss_right = 0; btns = 4'hF;
    model_reset();
    @(negedge CLK); @(negedge CLK);
    rst_n = 1;
    compare_model("reset");
    for (int i = 0; i < 3; i++) begin
      cycle(1, 4'hF, 0, 0);
      check("held_btn_phase", int'(phase), S_IDLE);
    end
    cycle(0, 4'h0, 0, 0); check("release_phase", int'(phase), S_IDLE);
    cycle(0, 4'h1, 0, 0); check("press_phase", int'(phase), S_SERVE);
    check("press_p1", int'(score_p1), 0);
    check("press_p2", int'(score_p2), 0);
    cycle(0, 4'h0, 0, 0);

    // Directed vectors: serve countdown, first ball step, single and double miss.
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].t, tbl[i].b, tbl[i].l, tbl[i].r);
      check($sformatf("tbl%0d.phase", i), int'(phase),          tbl[i].ph);
      check($sformatf("tbl%0d.p1", i),    int'(score_p1),       tbl[i].p1);
      check($sformatf("tbl%0d.p2", i),    int'(score_p2),       tbl[i].p2);
      check($sformatf("tbl%0d.dir", i),   int'(serve_dir),      tbl[i].dir);
      check($sformatf("tbl%0d.hold", i),  int'(ball_hold),      tbl[i].hold);
      check($sformatf("tbl%0d.ball", i),  int'(ball_step_en),   tbl[i].ball);
      check($sformatf("tbl%0d.pad", i),   int'(paddle_step_en), tbl[i].pad);
    end

    // Player 2 wins with four left misses; early presses in game-over are ignored.
    for (int k = 0; k < 4; k++) play_point(1, 0);
    check("over_phase", int'(phase), S_OVER);
    check("over_winner", int'(winner), 1);
    check("over_p2", int'(score_p2), WIN);
    check("over_p1", int'(score_p1), 1);
    cycle(0, 4'h0, 0, 0);
    cycle(0, 4'h4, 0, 0); check("early_press0", int'(phase), S_OVER);
    cycle(0, 4'h0, 0, 0);
    for (int i = 0; i < OVR - 1; i++) cycle(1, 0, 0, 0);
    cycle(0, 4'h4, 0, 0); check("early_press_last", int'(phase), S_OVER);
    cycle(0, 4'h0, 0, 0);
    cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 1);
    check("over_miss_p1", int'(score_p1), 1);
    check("over_miss_p2", int'(score_p2), WIN);
    cycle(0, 4'h8, 0, 0); check("late_press_phase", int'(phase), S_IDLE);
    check("idle_keeps_p2", int'(score_p2), WIN);
    cycle(0, 4'h0, 0, 0);
    compare_model("after_over");

    // Reach 3/2 mid-PLAY, then pull reset between clock edges.
    cycle(0, 4'h2, 0, 0); check("restart_p2", int'(score_p2), 0);
    cycle(0, 4'h0, 0, 0);
    for (int k = 0; k < 3; k++) play_point(0, 1);
    for (int k = 0; k < 2; k++) play_point(1, 0);
    for (int i = 0; i < SRV; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("pre_rst_ball", int'(ball_step_en), 1);
    check("pre_rst_p1", int'(score_p1), 3);
    check("pre_rst_p2", int'(score_p2), 2);
    #2 rst_n = 0;
    #1;
    check("async_phase", int'(phase), S_IDLE);
    check("async_p1", int'(score_p1), 0);
    check("async_p2", int'(score_p2), 0);
    check("async_hold", int'(ball_hold), 1);
    check("async_ball", int'(ball_step_en), 0);
    check("async_pad", int'(paddle_step_en), 0);
    check("async_dir", int'(serve_dir), 0);
    check("async_winner", int'(winner), 0);
    model_reset();
    btns = 4'h0;
    @(negedge CLK);
    rst_n = 1;

    // Randomized play against the model.
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] b = btns;
      if ($urandom_range(7) == 0) b = ($urandom_range(1) == 0) ? 4'($urandom) : 4'h0;
      cycle($urandom_range(2) == 0, b, $urandom_range(11) == 0, $urandom_range(11) == 0);
      compare_model("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
